reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive stable cycles needed to accept a button level change (10 ms at 50 MHz).
REQ-002 The block SHALL have parameter RESET_HOLD_CYCLES, default 16: cycles mcu_reset stays high after the button is released.
REQ-003 The block SHALL have parameter BUTTON_ACTIVE_HIGH, default 1: 1 means pressed = button_in high; 0 means pressed = button_in low.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high global reset.
REQ-006 The block SHALL have port button_in, input, 1 bit: raw asynchronous push-button level.
REQ-007 The block SHALL have port halt_request, input, 1 bit: synchronous request to halt the core.
REQ-008 The block SHALL have port mcu_reset, output, 1 bit: reset to the MCU, active-high, registered.
REQ-009 The block SHALL have port mcu_halt, output, 1 bit: halt to the MCU, active-high, registered.
REQ-010 The block SHALL have port ready, output, 1 bit: high only while in RUN.

Function
REQ-011 button_in SHALL pass through a 2-flop synchronizer, then be polarity-corrected to btn_sync (1 = pressed).
REQ-012 The debouncer SHALL keep btn_stable plus a counter; counter clears on any cycle btn_sync == btn_stable and increments otherwise.
REQ-013 btn_stable SHALL toggle, and the counter clear, on the edge where the counter equals DEBOUNCE_CYCLES-1 while btn_sync != btn_stable, i.e. after DEBOUNCE_CYCLES consecutive differing cycles.
REQ-014 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave btn_stable unchanged.
REQ-015 A press event SHALL be the btn_stable 0->1 transition; the release event is 1->0.
REQ-016 The FSM SHALL have three states: HOLD, RUN and HALTED.
REQ-017 In HOLD, mcu_reset SHALL be 1 and mcu_halt 0.
REQ-018 The hold counter SHALL stay 0 while btn_stable = 1 and increment each cycle btn_stable = 0.
REQ-019 At hold count RESET_HOLD_CYCLES-1, the FSM SHALL go to HALTED if halt_request = 1, else RUN.
REQ-020 In RUN, mcu_reset and mcu_halt SHALL be 0 and ready 1; halt_request = 1 SHALL move the FSM to HALTED on the next edge.
REQ-021 In HALTED, mcu_halt SHALL be 1 and mcu_reset 0; halt_request = 0 SHALL move the FSM to RUN on the next edge.
REQ-022 A press event in RUN or HALTED SHALL move the FSM to HOLD with the hold counter cleared.
REQ-023 A press event SHALL take priority over halt_request in the same cycle.
REQ-024 A press event in HOLD SHALL clear the hold counter.
REQ-025 Outputs SHALL be registered from next-state, so mcu_reset/mcu_halt/ready change on the same edge as the state.
REQ-026 Counters SHALL be sized with $clog2 of their parameter, never wrap, and saturate at their terminal value.
REQ-027 DEBOUNCE_CYCLES and RESET_HOLD_CYCLES SHALL each be >= 1; a value of 0 is a configuration error, flagged by a simulation-time check.

Reset
REQ-028 With reset = 1 at an edge: state HOLD, hold and debounce counters 0, synchronizer flops and btn_stable 0, mcu_reset 1, mcu_halt 0, ready 0.
REQ-029 reset SHALL override every other input, including a mid-debounce or mid-hold operation.
REQ-030 After reset deasserts with the button released, mcu_reset SHALL stay high for exactly RESET_HOLD_CYCLES further cycles.

Verification (DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=3, BUTTON_ACTIVE_HIGH=1)
REQ-031 Power-up: reset high 2 cycles, then low, button 0, halt_request 0 -> mcu_reset 1 for 3 cycles, then 0 with ready 1 and mcu_halt 0.
REQ-032 Glitch: button_in high 3 cycles in RUN -> btn_stable stays 0 and state stays RUN.
REQ-033 Press: button_in high 10 cycles -> mcu_reset rises 2+4 cycles after button rise, stays high while pressed, and falls 3 cycles after btn_stable falls.
REQ-034 Halt: halt_request 1 in RUN -> mcu_halt 1 and ready 0 next edge; halt_request 0 -> RUN next edge.
REQ-035 Collision: press event and halt_request 1 in the same cycle -> HOLD (mcu_reset 1, mcu_halt 0); with halt_request still 1 at hold end -> HALTED.
REQ-036 Mid-op reset: reset pulsed 1 cycle during HALTED with btn_stable 1 -> all reset values per REQ-028 next edge, btn_stable 0.

Source files
------------

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Debounced push-button reset sequencer with halt control for an MCU.
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int DEBOUNCE_CYCLES    = 500000,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int BUTTON_ACTIVE_HIGH = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    input  logic halt_request,
    output logic mcu_reset,
    output logic mcu_halt,
    output logic ready
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("reset_sequencer: DEBOUNCE_CYCLES must be >= 1");
        end
        if (RESET_HOLD_CYCLES < 1) begin : g_bad_hold
            $error("reset_sequencer: RESET_HOLD_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    logic              sync1_q;
    logic              sync2_q;
    logic              btn_sync;
    logic              btn_stable_q;
    logic              btn_stable_d;
    logic [DB_W-1:0]   db_cnt_q;
    logic [DB_W-1:0]   db_cnt_d;
    logic              press_event;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    state_e            state_q;
    state_e            state_d;
    logic              mcu_reset_q;
    logic              mcu_halt_q;
    logic              ready_q;

    assign btn_sync = (BUTTON_ACTIVE_HIGH != 0) ? sync2_q : ~sync2_q;

    // Terminal count is reached only while the levels differ, so the counter
    // can never run past DB_LAST.
    always_comb begin
        btn_stable_d = btn_stable_q;
        db_cnt_d     = '0;
        press_event  = 1'b0;
        if (btn_sync != btn_stable_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_stable_d = ~btn_stable_q;
                press_event  = ~btn_stable_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            btn_stable_q <= 1'b0;
            db_cnt_q     <= '0;
        end else begin
            sync1_q      <= button_in;
            sync2_q      <= sync1_q;
            btn_stable_q <= btn_stable_d;
            db_cnt_q     <= db_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        if (press_event) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (btn_stable_q) begin
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_d = '0;
                        state_d    = halt_request ? ST_HALTED : ST_RUN;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    hold_cnt_d = '0;
                    if (halt_request) begin
                        state_d = ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    hold_cnt_d = '0;
                    if (!halt_request) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    // Outputs decode the next state so they switch on the same edge as state_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            mcu_reset_q <= 1'b1;
            mcu_halt_q  <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            mcu_reset_q <= (state_d == ST_HOLD);
            mcu_halt_q  <= (state_d == ST_HALTED);
            ready_q     <= (state_d == ST_RUN);
        end
    end

    assign mcu_reset = mcu_reset_q;
    assign mcu_halt  = mcu_halt_q;
    assign ready     = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_sequencer
// Purpose  : Self-checking bench for reset_sequencer against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int DB   = 4;
    localparam int HOLD = 3;

    localparam int M_HOLD   = 0;
    localparam int M_RUN    = 1;
    localparam int M_HALTED = 2;

    logic clock;
    logic reset;
    logic button_in;
    logic halt_request;
    logic mcu_reset;
    logic mcu_halt;
    logic ready;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic m_s1, m_s2, m_stable;
    int   m_diff_run;
    int   m_held;
    int   m_mode;

    reset_sequencer #(
        .DEBOUNCE_CYCLES   (DB),
        .RESET_HOLD_CYCLES (HOLD),
        .BUTTON_ACTIVE_HIGH(1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .button_in   (button_in),
        .halt_request(halt_request),
        .mcu_reset   (mcu_reset),
        .mcu_halt    (mcu_halt),
        .ready       (ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of the reference: the button level must disagree with the
    // accepted level for DB consecutive synchronized samples to be accepted.
    task automatic model_step(input logic r, input logic b, input logic h);
        logic sampled;
        logic old_stable;
        logic press;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_stable = 0;
            m_diff_run = 0; m_held = 0; m_mode = M_HOLD;
            return;
        end
        sampled    = m_s2;
        old_stable = m_stable;
        m_s2       = m_s1;
        m_s1       = b;
        press      = 0;
        if (sampled != old_stable) begin
            m_diff_run++;
            if (m_diff_run == DB) begin
                m_stable   = sampled;
                m_diff_run = 0;
                press      = sampled;
            end
        end else begin
            m_diff_run = 0;
        end
        if (press) begin
            m_mode = M_HOLD;
            m_held = 0;
        end else if (m_mode == M_HOLD) begin
            if (old_stable) begin
                m_held = 0;
            end else if (m_held + 1 == HOLD) begin
                m_held = 0;
                m_mode = h ? M_HALTED : M_RUN;
            end else begin
                m_held++;
            end
        end else if (m_mode == M_RUN) begin
            if (h) m_mode = M_HALTED;
        end else begin
            if (!h) m_mode = M_RUN;
        end
    endtask

    task automatic tick(input logic r, input logic b, input logic h);
        reset        = r;
        button_in    = b;
        halt_request = h;
        @(posedge clock);
        model_step(r, b, h);
        #1;
        check_eq("mcu_reset", {31'd0, mcu_reset}, {31'd0, m_mode == M_HOLD});
        check_eq("mcu_halt",  {31'd0, mcu_halt},  {31'd0, m_mode == M_HALTED});
        check_eq("ready",     {31'd0, ready},     {31'd0, m_mode == M_RUN});
        check_eq("btn_stable", {31'd0, dut.btn_stable_q}, {31'd0, m_stable});
    endtask

    initial begin
        int n;
        logic rb, rh, rr;
        int len;
        reset = 1'b1; button_in = 1'b0; halt_request = 1'b0;

        // Power-up
        tick(1, 0, 0);
        tick(1, 0, 0);
        check_eq("pwr_reset_rst", {31'd0, mcu_reset}, 32'd1);
        check_eq("pwr_ready_rst", {31'd0, ready}, 32'd0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        check_eq("pwr_reset_held", {31'd0, mcu_reset}, 32'd1);
        tick(0, 0, 0);
        check_eq("pwr_reset_done", {31'd0, mcu_reset}, 32'd0);
        check_eq("pwr_ready", {31'd0, ready}, 32'd1);
        check_eq("pwr_halt", {31'd0, mcu_halt}, 32'd0);

        // Glitch shorter than the debounce window
        repeat (3) tick(0, 1, 0);
        repeat (6) tick(0, 0, 0);
        check_eq("glitch_stable", {31'd0, dut.btn_stable_q}, 32'd0);
        check_eq("glitch_ready", {31'd0, ready}, 32'd1);

        // Press latency and release latency
        n = 0;
        do begin tick(0, 1, 0); n++; end while (!mcu_reset && n < 20);
        check_eq("press_latency", n, 32'd6);
        repeat (10 - n) tick(0, 1, 0);
        n = 0;
        do begin tick(0, 0, 0); n++; end while (mcu_reset && n < 30);
        check_eq("release_latency", n, 32'd9);

        // Halt request
        tick(0, 0, 1);
        check_eq("halt_on", {31'd0, mcu_halt}, 32'd1);
        check_eq("halt_ready", {31'd0, ready}, 32'd0);
        tick(0, 0, 0);
        check_eq("halt_off", {31'd0, ready}, 32'd1);

        // Press and halt in the same cycle
        repeat (5) tick(0, 1, 0);
        tick(0, 1, 1);
        check_eq("coll_reset", {31'd0, mcu_reset}, 32'd1);
        check_eq("coll_halt", {31'd0, mcu_halt}, 32'd0);
        repeat (4) tick(0, 1, 1);
        n = 0;
        do begin tick(0, 0, 1); n++; end while (!mcu_halt && n < 30);
        check_eq("coll_halted", {31'd0, mcu_halt}, 32'd1);
        check_eq("coll_halted_rst", {31'd0, mcu_reset}, 32'd0);

        // Reset mid-debounce while halted, then mid-hold with button accepted
        repeat (2) tick(0, 1, 1);
        tick(1, 1, 1);
        check_eq("mid_rst_reset", {31'd0, mcu_reset}, 32'd1);
        check_eq("mid_rst_halt", {31'd0, mcu_halt}, 32'd0);
        repeat (8) tick(0, 1, 1);
        check_eq("mid_hold_stable", {31'd0, dut.btn_stable_q}, 32'd1);
        tick(1, 1, 1);
        check_eq("mid_hold_rst_stable", {31'd0, dut.btn_stable_q}, 32'd0);
        check_eq("mid_hold_rst_ready", {31'd0, ready}, 32'd0);
        repeat (10) tick(0, 0, 0);

        // Randomized segments
        for (int i = 0; i < 400; i++) begin
            rb  = 1'($urandom_range(0, 1));
            rh  = ($urandom_range(0, 3) == 0);
            rr  = ($urandom_range(0, 39) == 0);
            len = $urandom_range(1, 9);
            if (rr) tick(1, rb, rh);
            for (int k = 0; k < len; k++) tick(0, rb, rh);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
